// File: rtl/wb_regfile2.sv
// wb_regfile2: dual-lane writeback select, 32x32 register file with four
// combinational read ports (write-through bypass) and a committed-write counter.
module wb_regfile2 #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write0,
    input  logic              reg_write1,
    input  logic              mem_2_reg0,
    input  logic              mem_2_reg1,
    input  logic [4:0]        rd0,
    input  logic [4:0]        rd1,
    input  logic [DATA_W-1:0] alu_data0,
    input  logic [DATA_W-1:0] alu_data1,
    input  logic [DATA_W-1:0] mem_data0,
    input  logic [DATA_W-1:0] mem_data1,
    input  logic [4:0]        ra0,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [4:0]        ra3,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3,
    output logic [DATA_W-1:0] wb_data0,
    output logic [DATA_W-1:0] wb_data1,
    output logic              wb_en0,
    output logic              wb_en1,
    output logic [CNT_W-1:0]  wr_count
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [4:0]        ra_a   [4];
    logic [DATA_W-1:0] rd_a   [4];

    // Per-lane result select; a clean select keeps an X on the unused source out.
    assign wb_data0 = mem_2_reg0 ? mem_data0 : alu_data0;
    assign wb_data1 = mem_2_reg1 ? mem_data1 : alu_data1;

    // r0 writes and anything presented during reset never commit.
    assign wb_en0 = reg_write0 && (rd0 != 5'd0) && !rst;
    assign wb_en1 = reg_write1 && (rd1 != 5'd0) && !rst;

    assign ra_a[0] = ra0;
    assign ra_a[1] = ra1;
    assign ra_a[2] = ra2;
    assign ra_a[3] = ra3;

    // Read ports: younger lane bypass beats older lane, which beats the array.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_a[k] = '0;
            if (!rst && ra_a[k] != 5'd0) begin
                if (wb_en1 && rd1 == ra_a[k]) begin
                    rd_a[k] = wb_data1;
                end else if (wb_en0 && rd0 == ra_a[k]) begin
                    rd_a[k] = wb_data0;
                end else begin
                    rd_a[k] = regs_q[ra_a[k]];
                end
            end
        end
    end

    assign rdata0 = rd_a[0];
    assign rdata1 = rd_a[1];
    assign rdata2 = rd_a[2];
    assign rdata3 = rd_a[3];

    // Commit; lane 1 is written last so it wins a same-destination collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wb_en0) begin
                regs_q[rd0] <= wb_data0;
            end
            if (wb_en1) begin
                regs_q[rd1] <= wb_data1;
            end
        end
    end

    // Next committed-write count; a collision still counts as two writes.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(wb_en0) + CNT_W'(wb_en1);
    end

    // Counter register, wraps modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wr_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile2.sv
// tb_wb_regfile2: directed stimulus, per-cycle model comparison on the
// falling edge, plus literal checks of the expected values.
module tb_wb_regfile2;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write0, reg_write1;
    logic        mem_2_reg0, mem_2_reg1;
    logic [4:0]  rd0, rd1;
    logic [31:0] alu_data0, alu_data1;
    logic [31:0] mem_data0, mem_data1;
    logic [4:0]  ra0, ra1, ra2, ra3;
    logic [31:0] rdata0, rdata1, rdata2, rdata3;
    logic [31:0] wb_data0, wb_data1;
    logic        wb_en0, wb_en1;
    logic [31:0] wr_count;
    logic [31:0] s_rdata0, s_rdata1, s_rdata2, s_rdata3;
    logic [31:0] s_wb_data0, s_wb_data1;
    logic        s_wb_en0, s_wb_en1;
    logic [3:0]  s_wr_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    int unsigned m_cnt;

    always #5 clk = ~clk;

    wb_regfile2 dut (
        .clk(clk), .rst(rst),
        .reg_write0(reg_write0), .reg_write1(reg_write1),
        .mem_2_reg0(mem_2_reg0), .mem_2_reg1(mem_2_reg1),
        .rd0(rd0), .rd1(rd1),
        .alu_data0(alu_data0), .alu_data1(alu_data1),
        .mem_data0(mem_data0), .mem_data1(mem_data1),
        .ra0(ra0), .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rdata0(rdata0), .rdata1(rdata1),
        .rdata2(rdata2), .rdata3(rdata3),
        .wb_data0(wb_data0), .wb_data1(wb_data1),
        .wb_en0(wb_en0), .wb_en1(wb_en1),
        .wr_count(wr_count)
    );

    wb_regfile2 #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .reg_write0(reg_write0), .reg_write1(reg_write1),
        .mem_2_reg0(mem_2_reg0), .mem_2_reg1(mem_2_reg1),
        .rd0(rd0), .rd1(rd1),
        .alu_data0(alu_data0), .alu_data1(alu_data1),
        .mem_data0(mem_data0), .mem_data1(mem_data1),
        .ra0(ra0), .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .rdata0(s_rdata0), .rdata1(s_rdata1),
        .rdata2(s_rdata2), .rdata3(s_rdata3),
        .wb_data0(s_wb_data0), .wb_data1(s_wb_data1),
        .wb_en0(s_wb_en0), .wb_en1(s_wb_en1),
        .wr_count(s_wr_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_wb(input int lane);
        if (lane == 0) return mem_2_reg0 ? mem_data0 : alu_data0;
        return mem_2_reg1 ? mem_data1 : alu_data1;
    endfunction

    function automatic logic m_en(input int lane);
        if (rst) return 1'b0;
        if (lane == 0) return reg_write0 && rd0 != 0;
        return reg_write1 && rd1 != 0;
    endfunction

    // What register a reads as right now, including this cycle's writes.
    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (m_en(1) && rd1 == a) return m_wb(1);
        if (m_en(0) && rd0 == a) return m_wb(0);
        return m_regs[a];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 0;
    end

    // Model state update: architectural effect of each edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 0;
        end else begin
            if (m_en(0)) m_regs[rd0] = m_wb(0);
            if (m_en(1)) m_regs[rd1] = m_wb(1);
            m_cnt = m_cnt + int'(m_en(0)) + int'(m_en(1));
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("rdata0", rdata0, m_rd(ra0));
        chk("rdata1", rdata1, m_rd(ra1));
        chk("rdata2", rdata2, m_rd(ra2));
        chk("rdata3", rdata3, m_rd(ra3));
        chk("wb_data0", wb_data0, m_wb(0));
        chk("wb_data1", wb_data1, m_wb(1));
        chk("wb_en0", {31'b0, wb_en0}, {31'b0, m_en(0)});
        chk("wb_en1", {31'b0, wb_en1}, {31'b0, m_en(1)});
        chk("wr_count", wr_count, m_cnt);
        chk("s_wr_count", {28'b0, s_wr_count}, m_cnt % 16);
        chk("s_rdata0", s_rdata0, m_rd(ra0));
    end

    task automatic idle();
        reg_write0 = 0; reg_write1 = 0;
        mem_2_reg0 = 0; mem_2_reg1 = 0;
        rd0 = 0; rd1 = 0;
        alu_data0 = 0; alu_data1 = 0;
        mem_data0 = 0; mem_data1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic w0(input logic [4:0] r, input logic [31:0] v);
        reg_write0 = 1; rd0 = r; alu_data0 = v; mem_2_reg0 = 0;
    endtask

    task automatic w1(input logic [4:0] r, input logic [31:0] v);
        reg_write1 = 1; rd1 = r; alu_data1 = v; mem_2_reg1 = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        ra0 = 0; ra1 = 0; ra2 = 0; ra3 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        ra0 = 1; ra1 = 5; ra2 = 17; ra3 = 31;
        @(negedge clk);
        chk("L rst rd0", rdata0, 32'h0);
        chk("L rst rd1", rdata1, 32'h0);
        chk("L rst rd2", rdata2, 32'h0);
        chk("L rst rd3", rdata3, 32'h0);
        chk("L rst cnt", wr_count, 32'h0);

        // Lane 0 ALU write with X on the unused load source
        step();
        w0(5, 32'hDEADBEEF);
        mem_data0 = 'x;
        @(negedge clk);
        chk("L byp r5", rdata1, 32'hDEADBEEF);
        chk("L wbd0 x", wb_data0, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("L arr r5", rdata1, 32'hDEADBEEF);
        chk("L cnt1", wr_count, 32'd1);

        // Lane 1 load select
        step();
        reg_write1 = 1; rd1 = 7; mem_2_reg1 = 1;
        mem_data1 = 32'h12345678; alu_data1 = 32'hFFFFFFFF;
        @(negedge clk);
        chk("L wbd1 mem", wb_data1, 32'h12345678);
        step();
        ra2 = 7;
        @(negedge clk);
        chk("L arr r7", rdata2, 32'h12345678);

        // Same-destination collision
        step();
        ra0 = 9;
        w0(9, 32'h1111);
        w1(9, 32'h2222);
        @(negedge clk);
        chk("L coll byp", rdata0, 32'h2222);
        step();
        @(negedge clk);
        chk("L coll arr", rdata0, 32'h2222);
        chk("L coll cnt", wr_count, 32'd4);

        // Lane 0 bypass over stale array value
        step();
        w0(9, 32'h3333);
        @(negedge clk);
        chk("L byp0", rdata0, 32'h3333);

        // Register 0 writes
        step();
        ra0 = 0;
        w0(0, 32'hABCD);
        w1(0, 32'hABCD);
        @(negedge clk);
        chk("L r0 en0", {31'b0, wb_en0}, 32'h0);
        chk("L r0 en1", {31'b0, wb_en1}, 32'h0);
        chk("L r0 rd", rdata0, 32'h0);
        step();
        @(negedge clk);
        chk("L r0 cnt", wr_count, 32'd5);

        // Reset mid-stream with a pending write
        step();
        w0(1, 32'h101); w1(2, 32'h102);
        step();
        w0(3, 32'h103); w1(4, 32'h104);
        step();
        ra0 = 1; ra1 = 2; ra2 = 3; ra3 = 4;
        @(negedge clk);
        chk("L fill r3", rdata2, 32'h103);
        chk("L fill cnt", wr_count, 32'd9);
        @(posedge clk);
        #1;
        rst = 1;
        w0(3, 32'h333);
        @(negedge clk);
        chk("L mid rd2", rdata2, 32'h0);
        chk("L mid en0", {31'b0, wb_en0}, 32'h0);
        step();
        rst = 0;
        @(negedge clk);
        chk("L post r1", rdata0, 32'h0);
        chk("L post r2", rdata1, 32'h0);
        chk("L post r3", rdata2, 32'h0);
        chk("L post r4", rdata3, 32'h0);
        chk("L post cnt", wr_count, 32'h0);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            step();
            w0(10, 32'(i + 1));
        end
        step();
        ra0 = 10;
        @(negedge clk);
        chk("L wrap s", {28'b0, s_wr_count}, 32'd1);
        chk("L wrap w", wr_count, 32'd17);
        chk("L wrap r10", rdata0, 32'd17);

        step();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
